// File: rtl/de_regfile_pkg.sv
// Shared constants for the decode-stage register file: bundle widths, CSR map
// and the CSR address decoder.
package de_regfile_pkg;

   localparam int unsigned DBITS_DEF           = 32;
   localparam int unsigned REGNOBITS_DEF       = 5;
   localparam int unsigned CSRNOBITS_DEF       = 12;
   localparam int unsigned FROM_WB_TO_DE_WIDTH = 2 + REGNOBITS_DEF + DBITS_DEF + CSRNOBITS_DEF;

   localparam logic [CSRNOBITS_DEF-1:0] CSR_MSTATUS = 12'h300;
   localparam logic [CSRNOBITS_DEF-1:0] CSR_MTVEC   = 12'h305;
   localparam logic [CSRNOBITS_DEF-1:0] CSR_MEPC    = 12'h341;
   localparam logic [CSRNOBITS_DEF-1:0] CSR_MCAUSE  = 12'h342;

   localparam int unsigned CSR_COUNT = 4;

   typedef enum logic [1:0] {
      CsrMstatus = 2'd0,
      CsrMtvec   = 2'd1,
      CsrMepc    = 2'd2,
      CsrMcause  = 2'd3
   } csr_sel_e;

   typedef struct packed {
      logic     hit;
      csr_sel_e sel;
   } csr_dec_t;

   function automatic csr_dec_t csr_decode(input logic [CSRNOBITS_DEF-1:0] addr);
      csr_dec_t dec;
      dec.hit = 1'b1;
      dec.sel = CsrMstatus;
      case (addr)
         CSR_MSTATUS: dec.sel = CsrMstatus;
         CSR_MTVEC:   dec.sel = CsrMtvec;
         CSR_MEPC:    dec.sel = CsrMepc;
         CSR_MCAUSE:  dec.sel = CsrMcause;
         default:     dec.hit = 1'b0;
      endcase
      return dec;
   endfunction

endpackage

// File: rtl/de_sb_counter.sv
// One pending-write counter of the decode scoreboard. err_o flags an attempted
// overflow or underflow in the current cycle; the count holds in that case.
module de_sb_counter #(
   parameter int unsigned SBBITS = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inc_i,
   input  logic              dec_i,
   output logic [SBBITS-1:0] cnt_o,
   output logic              err_o
);

   localparam logic [SBBITS-1:0] CntMax = '1;

   logic [SBBITS-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      err_o = 1'b0;
      if (inc_i && !dec_i) begin
         if (cnt_q == CntMax) err_o = 1'b1;
         else                 cnt_d = cnt_q + 1'b1;
      end else if (dec_i && !inc_i) begin
         if (cnt_q == '0) err_o = 1'b1;
         else             cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/de_regfile.sv
// Decode-stage GPR/CSR register file fed by write-back, with same-cycle WB
// bypass and a per-GPR pending-write scoreboard for hazard stalls.
module de_regfile
   import de_regfile_pkg::*;
#(
   parameter int unsigned DBITS     = 32,
   parameter int unsigned REGNOBITS = 5,
   parameter int unsigned REGWORDS  = 32,
   parameter int unsigned CSRNOBITS = 12,
   parameter int unsigned SBBITS    = 2
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [REGNOBITS+DBITS+CSRNOBITS+1:0]  from_WB_to_DE,
   input  logic                                  issue_valid,
   input  logic                                  issue_wr,
   input  logic [REGNOBITS-1:0]                  issue_rd,
   input  logic [REGNOBITS-1:0]                  rs1_no,
   input  logic [REGNOBITS-1:0]                  rs2_no,
   input  logic [CSRNOBITS-1:0]                  csr_rdno,
   output logic [DBITS-1:0]                      rs1_val,
   output logic [DBITS-1:0]                      rs2_val,
   output logic                                  rs1_busy,
   output logic                                  rs2_busy,
   output logic                                  rd_full,
   output logic [DBITS-1:0]                      csr_val,
   output logic                                  csr_wr_err,
   output logic                                  sb_err
);

   localparam int unsigned ValLsb   = CSRNOBITS + 1;
   localparam int unsigned RegLsb   = ValLsb + DBITS;
   localparam int unsigned WrRegBit = RegLsb + REGNOBITS;
   localparam logic [SBBITS-1:0] CntMax = '1;

   logic                 wr_reg, wr_csr;
   logic [REGNOBITS-1:0] wregno;
   logic [DBITS-1:0]     regval;
   logic [CSRNOBITS-1:0] wcsrno;

   assign wr_csr = from_WB_to_DE[0];
   assign wcsrno = from_WB_to_DE[1 +: CSRNOBITS];
   assign regval = from_WB_to_DE[ValLsb +: DBITS];
   assign wregno = from_WB_to_DE[RegLsb +: REGNOBITS];
   assign wr_reg = from_WB_to_DE[WrRegBit];

   logic [DBITS-1:0] rf_q  [REGWORDS];
   logic [DBITS-1:0] rf_d  [REGWORDS];
   logic [DBITS-1:0] csr_q [CSR_COUNT];
   logic [DBITS-1:0] csr_d [CSR_COUNT];
   logic             csr_wr_err_q, csr_wr_err_d;
   logic             sb_err_q, sb_err_d;

   csr_dec_t wdec, rdec;
   assign wdec = csr_decode(wcsrno);
   assign rdec = csr_decode(csr_rdno);

   // Scoreboard: one counter per architectural register except x0
   logic [SBBITS-1:0]   cnt [REGWORDS];
   logic [REGWORDS-1:1] inc, dec, cnt_err;

   assign cnt[0] = '0;

   always_comb begin
      for (int unsigned r = 1; r < REGWORDS; r++) begin
         inc[r] = issue_valid && issue_wr && (issue_rd == REGNOBITS'(r));
         dec[r] = wr_reg && (wregno == REGNOBITS'(r));
      end
   end

   for (genvar r = 1; r < REGWORDS; r++) begin : g_sb
      de_sb_counter #(
         .SBBITS (SBBITS)
      ) u_cnt (
         .clk   (clk),
         .reset (reset),
         .inc_i (inc[r]),
         .dec_i (dec[r]),
         .cnt_o (cnt[r]),
         .err_o (cnt_err[r])
      );
   end

   always_comb begin
      rf_d  = rf_q;
      csr_d = csr_q;
      if (wr_reg && wregno != '0) rf_d[wregno] = regval;
      if (wr_csr && wdec.hit) csr_d[wdec.sel] = regval;
      csr_wr_err_d = wr_csr && !wdec.hit;
      sb_err_d     = sb_err_q || (|cnt_err);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_q         <= '{default: '0};
         csr_q        <= '{default: '0};
         csr_wr_err_q <= 1'b0;
         sb_err_q     <= 1'b0;
      end else begin
         rf_q         <= rf_d;
         csr_q        <= csr_d;
         csr_wr_err_q <= csr_wr_err_d;
         sb_err_q     <= sb_err_d;
      end
   end

   // Combinational outputs are forced low while reset is asserted
   always_comb begin
      rs1_val  = '0;
      rs2_val  = '0;
      rs1_busy = 1'b0;
      rs2_busy = 1'b0;
      rd_full  = 1'b0;
      csr_val  = '0;
      if (!reset) begin
         if (rs1_no != '0) begin
            rs1_val  = (wr_reg && wregno == rs1_no) ? regval : rf_q[rs1_no];
            rs1_busy = (cnt[rs1_no] != '0) &&
                       !(wr_reg && wregno == rs1_no && cnt[rs1_no] == SBBITS'(1));
         end
         if (rs2_no != '0) begin
            rs2_val  = (wr_reg && wregno == rs2_no) ? regval : rf_q[rs2_no];
            rs2_busy = (cnt[rs2_no] != '0) &&
                       !(wr_reg && wregno == rs2_no && cnt[rs2_no] == SBBITS'(1));
         end
         rd_full = issue_wr && (issue_rd != '0) && (cnt[issue_rd] == CntMax) &&
                   !(wr_reg && wregno == issue_rd);
         // Bypass only hits mapped CSRs: a dropped write must never become visible
         if (rdec.hit) begin
            csr_val = (wr_csr && wcsrno == csr_rdno) ? regval : csr_q[rdec.sel];
         end
      end
   end

   assign csr_wr_err = csr_wr_err_q;
   assign sb_err     = sb_err_q;

endmodule
